mem_bus_router: RTL and testbench

- Parametrised, sequential successor to the MIPS memory-map decoder.
- Accepts one CPU data-bus transaction at a time through a req/ready handshake and decodes the address into one of N_SLV slave windows (DM, interrupt controller, factorial units, ...).
- Drives the selected slave with a held request until that slave acks or a timeout expires, then returns registered read data or completion with an error flag.
- Tracks bus errors: a saturating counter plus the last faulting address.

---
 rtl/mem_bus_router_if.sv | 39 +++
 rtl/mem_bus_router.sv | 115 +++++++++++
 tb/tb_mem_bus_router.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/mem_bus_router_if.sv
// Bus bundle between the CPU data port, the router and the slave windows.
// Ports: m_* is the CPU-facing request/response side, s_* the shared slave-facing side.
// Modport slave is the router's view; modport master is the surrounding system's view.
interface mem_bus_router_if #(
   parameter int N_SLV = 6,
   parameter int AW    = 32,
   parameter int DW    = 32
);
   // CPU side
   logic                m_req;
   logic                m_we;
   logic [AW-1:0]       m_addr;
   logic [DW-1:0]       m_wdata;
   logic                m_ready;
   logic                m_rvalid;
   logic [DW-1:0]       m_rdata;
   logic                m_err;
   // slave side
   logic [N_SLV-1:0]    s_req;
   logic                s_we;
   logic [AW-1:0]       s_addr;
   logic [DW-1:0]       s_wdata;
   logic [N_SLV*DW-1:0] s_rdata;
   logic [N_SLV-1:0]    s_ack;

   modport slave (
      input  m_req, m_we, m_addr, m_wdata,
      output m_ready, m_rvalid, m_rdata, m_err,
      output s_req, s_we, s_addr, s_wdata,
      input  s_rdata, s_ack
   );

   modport master (
      output m_req, m_we, m_addr, m_wdata,
      input  m_ready, m_rvalid, m_rdata, m_err,
      input  s_req, s_we, s_addr, s_wdata,
      output s_rdata, s_ack
   );
endinterface

// File: rtl/mem_bus_router.sv
// Purpose: decodes one CPU data-bus transaction at a time into N_SLV address windows and waits for the slave ack.
// Latency: in-range completion 2 + wait cycles after accept (timeout after TIMEOUT busy cycles); out-of-range 1 cycle.
// Backpressure: m_ready is low from accept until the cycle after the m_rvalid pulse; m_req is ignored meanwhile.
// Ports: clk, rst (sync, active high), bus (mem_bus_router_if.slave), err_count (saturating), err_addr (last fault).
module mem_bus_router #(
   parameter int N_SLV   = 6,
   parameter int AW      = 32,
   parameter int DW      = 32,
   parameter int SEL_LSB = 8,
   parameter int TIMEOUT = 15
) (
   input  logic          clk,
   input  logic          rst,
   mem_bus_router_if.slave bus,
   output logic [7:0]    err_count,
   output logic [AW-1:0] err_addr
);

   localparam int SW = (N_SLV > 1) ? $clog2(N_SLV) : 1;
   localparam int CW = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

   state_t           state;
   logic [SW-1:0]    idx;        // decoded index of the incoming address
   logic [SW-1:0]    sel;        // latched index of the transaction in flight
   logic [CW-1:0]    cnt;        // busy cycles without an ack, minus one
   logic             out_of_range;
   logic [N_SLV-1:0] idx_onehot;

   // Any set bit above the index field, or an index past the last window, is a miss.
   always_comb begin
      idx          = bus.m_addr[SEL_LSB +: SW];
      out_of_range = (int'(idx) >= N_SLV) || ((bus.m_addr >> (SEL_LSB + SW)) != '0);
      idx_onehot   = N_SLV'(1) << idx;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= IDLE;
         bus.m_ready  <= 1'b1;
         bus.m_rvalid <= 1'b0;
         bus.m_rdata  <= '0;
         bus.m_err    <= 1'b0;
         bus.s_req    <= '0;
         bus.s_we     <= 1'b0;
         bus.s_addr   <= '0;
         bus.s_wdata  <= '0;
         sel          <= '0;
         cnt          <= '0;
         err_count    <= '0;
         err_addr     <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.m_req) begin
                  bus.s_addr  <= bus.m_addr;
                  bus.s_we    <= bus.m_we;
                  bus.s_wdata <= bus.m_wdata;
                  sel         <= idx;
                  cnt         <= '0;
                  bus.m_ready <= 1'b0;
                  if (out_of_range) begin
                     // No slave is touched; answer with an error straight away.
                     state        <= RESP;
                     bus.m_rvalid <= 1'b1;
                     bus.m_err    <= 1'b1;
                     bus.m_rdata  <= '0;
                     err_addr     <= bus.m_addr;
                     if (err_count != 8'hFF) err_count <= err_count + 8'd1;
                  end else begin
                     state     <= BUSY;
                     bus.s_req <= idx_onehot;
                  end
               end
            end

            BUSY: begin
               // The ack is checked first so an ack in the final timeout cycle still wins.
               if (bus.s_ack[sel]) begin
                  state        <= RESP;
                  bus.s_req    <= '0;
                  bus.m_rvalid <= 1'b1;
                  bus.m_err    <= 1'b0;
                  bus.m_rdata  <= bus.s_we ? '0 : bus.s_rdata[sel*DW +: DW];
               end else if (cnt == CW'(TIMEOUT - 1)) begin
                  state        <= RESP;
                  bus.s_req    <= '0;
                  bus.m_rvalid <= 1'b1;
                  bus.m_err    <= 1'b1;
                  bus.m_rdata  <= '0;
                  err_addr     <= bus.s_addr;
                  if (err_count != 8'hFF) err_count <= err_count + 8'd1;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end

            RESP: begin
               state        <= IDLE;
               bus.m_rvalid <= 1'b0;
               bus.m_err    <= 1'b0;
               bus.m_ready  <= 1'b1;
            end

            default: begin
               state       <= IDLE;
               bus.m_ready <= 1'b1;
               bus.s_req   <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_bus_router.sv
// Purpose: directed test of mem_bus_router with a response scoreboard.
// Ports: none; drives the router through a mem_bus_router_if instance.
// Responses are checked by a monitor that pops expected data, error flag and cycle of arrival.
module tb_mem_bus_router;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [7:0]  err_count;
   logic [31:0] err_addr;

   mem_bus_router_if #(.N_SLV(6), .AW(32), .DW(32)) bus ();

   mem_bus_router #(
      .N_SLV(6), .AW(32), .DW(32), .SEL_LSB(8), .TIMEOUT(15)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .bus       (bus),
      .err_count (err_count),
      .err_addr  (err_addr)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] rdata;
      logic        err;
      int          cyc;
   } exp_t;

   exp_t sb[$];
   int   cyc = 0;
   int   n_chk = 0;
   int   n_fail = 0;
   int   sreq_cyc = 0;
   logic [5:0] last_sreq = '0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor: responses and s_req occupancy, sampled on the falling edge.
   always @(negedge clk) begin
      if (bus.s_req != '0) begin
         sreq_cyc++;
         last_sreq = bus.s_req;
      end
      if (bus.m_rvalid === 1'b1) begin
         if (sb.size() == 0) begin
            chk("unexpected_rvalid", 64'(bus.m_rvalid), 64'd0);
         end else begin
            exp_t e;
            e = sb.pop_front();
            chk("rdata", 64'(bus.m_rdata), 64'(e.rdata));
            chk("err", 64'(bus.m_err), 64'(e.err));
            chk("rvalid_cycle", 64'(cyc), 64'(e.cyc));
         end
      end
   end

   task automatic scramble_rdata();
      for (int i = 0; i < 6; i++) bus.s_rdata[i*32 +: 32] = $urandom;
   endtask

   task automatic wait_ready();
      int n = 0;
      while (bus.m_ready !== 1'b1 && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      if (n == 50) chk("ready_timeout", 64'(bus.m_ready), 64'd1);
   endtask

   task automatic wait_drain();
      int n = 0;
      while (sb.size() != 0 && n < 60) begin
         @(posedge clk); #1;
         n++;
      end
      if (n == 60) begin
         chk("response_timeout", 64'(sb.size()), 64'd0);
         sb.delete();
      end
   endtask

   // One transaction. ack_k < 0 means no ack; otherwise ack_bits are pulsed in busy cycle ack_k+1.
   // exp_lat is counted from the accept cycle (request sampled) to the m_rvalid cycle.
   task automatic do_txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                         input int ack_k, input logic [5:0] ack_bits, input int ack_slot,
                         input logic [31:0] ack_data, input logic [31:0] exp_rdata,
                         input logic exp_err, input int exp_lat,
                         input logic [5:0] exp_sreq, input int exp_sreq_cyc);
      exp_t e;
      wait_ready();
      bus.m_req   = 1'b1;
      bus.m_we    = we;
      bus.m_addr  = addr;
      bus.m_wdata = wdata;
      e.rdata = exp_rdata;
      e.err   = exp_err;
      e.cyc   = cyc + exp_lat;
      sb.push_back(e);
      sreq_cyc  = 0;
      last_sreq = '0;
      @(posedge clk); #1;
      // Change the master bus after accept: the router must work from its latched copy.
      bus.m_req   = 1'b0;
      bus.m_we    = ~we;
      bus.m_addr  = $urandom;
      bus.m_wdata = $urandom;
      if (ack_k >= 0) begin
         repeat (ack_k) begin
            @(posedge clk); #1;
            scramble_rdata();
         end
         bus.s_ack = ack_bits;
         bus.s_rdata[ack_slot*32 +: 32] = ack_data;
         @(posedge clk); #1;
         bus.s_ack = '0;
         scramble_rdata();
      end
      wait_drain();
      chk("sreq_cycles", 64'(sreq_cyc), 64'(exp_sreq_cyc));
      if (exp_sreq_cyc > 0) chk("sreq_onehot", 64'(last_sreq), 64'(exp_sreq));
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached, got running, expected finished");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.m_req   = 1'b0;
      bus.m_we    = 1'b0;
      bus.m_addr  = '0;
      bus.m_wdata = '0;
      bus.s_ack   = '0;
      scramble_rdata();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_m_ready", 64'(bus.m_ready), 64'd1);
      chk("rst_m_rvalid", 64'(bus.m_rvalid), 64'd0);
      chk("rst_m_rdata", 64'(bus.m_rdata), 64'd0);
      chk("rst_s_req", 64'(bus.s_req), 64'd0);
      chk("rst_err_count", 64'(err_count), 64'd0);
      chk("rst_err_addr", 64'(err_addr), 64'd0);
      @(posedge clk); #1;
      rst = 1'b0;

      // Read slave 0, ack in first busy cycle.
      do_txn(1'b0, 32'h0000_0010, 32'h0, 0, 6'b000001, 0, 32'hDEAD_BEEF,
             32'hDEAD_BEEF, 1'b0, 2, 6'b000001, 1);

      // Write slave 3, ack after 3 wait cycles; check the latched slave bus mid-transaction.
      fork
         do_txn(1'b1, 32'h0000_0304, 32'h5, 3, 6'b001000, 3, 32'hFFFF_FFFF,
                32'h0, 1'b0, 5, 6'b001000, 4);
         begin
            @(posedge clk); #1;   // accept edge happens at the first posedge
            @(posedge clk); #1;   // busy cycle 2
            chk("s_we", 64'(bus.s_we), 64'd1);
            chk("s_wdata", 64'(bus.s_wdata), 64'h5);
            chk("s_addr", 64'(bus.s_addr), 64'h304);
         end
      join

      // Out-of-range: index 6, then a set bit above the index field.
      do_txn(1'b0, 32'h0000_0600, 32'h0, -1, 6'b0, 0, 32'h0, 32'h0, 1'b1, 1, 6'b0, 0);
      do_txn(1'b0, 32'h0001_0000, 32'h0, -1, 6'b0, 0, 32'h0, 32'h0, 1'b1, 1, 6'b0, 0);
      chk("err_count_oor", 64'(err_count), 64'd2);
      chk("err_addr_oor", 64'(err_addr), 64'h0001_0000);

      // Timeout on slave 2, then the ack landing exactly in the 15th busy cycle.
      do_txn(1'b0, 32'h0000_0200, 32'h0, -1, 6'b0, 0, 32'h0, 32'h0, 1'b1, 16, 6'b000100, 15);
      chk("err_count_to", 64'(err_count), 64'd3);
      chk("err_addr_to", 64'(err_addr), 64'h0000_0200);
      do_txn(1'b0, 32'h0000_0204, 32'h0, 14, 6'b000100, 2, 32'h1234_5678,
             32'h1234_5678, 1'b0, 16, 6'b000100, 15);
      chk("err_count_late_ack", 64'(err_count), 64'd3);

      // Slave 1 selected but only slave 4 acks.
      do_txn(1'b0, 32'h0000_0100, 32'h0, 2, 6'b010000, 1, 32'hAAAA_5555,
             32'h0, 1'b1, 16, 6'b000010, 15);
      chk("err_count_wrong_ack", 64'(err_count), 64'd4);
      chk("err_addr_wrong_ack", 64'(err_addr), 64'h0000_0100);

      // Saturate the error counter.
      for (int i = 0; i < 300; i++)
         do_txn(1'b0, 32'h0000_0600, 32'h0, -1, 6'b0, 0, 32'h0, 32'h0, 1'b1, 1, 6'b0, 0);
      chk("err_count_sat", 64'(err_count), 64'd255);
      chk("err_addr_sat", 64'(err_addr), 64'h0000_0600);

      // Reset in the second busy cycle of a read of slave 5: no response may appear.
      wait_ready();
      bus.m_req  = 1'b1;
      bus.m_we   = 1'b0;
      bus.m_addr = 32'h0000_0500;
      @(posedge clk); #1;
      bus.m_req = 1'b0;
      chk("abort_s_req", 64'(bus.s_req), 64'b100000);
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      chk("abort_s_req_cleared", 64'(bus.s_req), 64'd0);
      chk("abort_m_ready", 64'(bus.m_ready), 64'd1);
      chk("abort_m_rvalid", 64'(bus.m_rvalid), 64'd0);
      chk("abort_err_count", 64'(err_count), 64'd0);
      chk("abort_err_addr", 64'(err_addr), 64'd0);
      repeat (4) @(posedge clk);
      #1;
      do_txn(1'b0, 32'h0000_0508, 32'h0, 1, 6'b100000, 5, 32'hCAFE_F00D,
             32'hCAFE_F00D, 1'b0, 3, 6'b100000, 2);

      repeat (3) @(posedge clk);
      #1;
      chk("scoreboard_empty", 64'(sb.size()), 64'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
